// File: rtl/fb_seq_pkg.sv
// Shared types and constants for the frame-buffer sequencer.
// States, handshake polarities and helper localparams.
package fb_seq_pkg;

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_INIT      = 3'd1,
    S_INIT_WAIT = 3'd2,
    S_PREFILL   = 3'd3,
    S_STREAM    = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  localparam int   ST_W       = 3;
  localparam logic ASSERT_L   = 1'b0;
  localparam logic DEASSERT_L = 1'b1;
  localparam logic ASSERT_H   = 1'b1;
  localparam logic DEASSERT_H = 1'b0;

endpackage

// File: rtl/fb_stream_seq_if.sv
// Bundle of init, cam FIFO, frame-buffer and ADV FIFO signals
// around the sequencer; master is the sequencer side.
interface fb_stream_seq_if #(
  parameter int NUM_FB = 3,
  parameter int IDX_W  = 2,
  parameter int DROP_W = 8
);
  logic              init_done;
  logic              init_start;
  logic              init_err;
  logic              cam_rdempty;
  logic              cam_rdreq;
  logic [NUM_FB-1:0] fb_full;
  logic [NUM_FB-1:0] fb_rd_done;
  logic [NUM_FB-1:0] fb_rd_valid;
  logic [NUM_FB-1:0] fb_wr_en_n;
  logic [NUM_FB-1:0] fb_rd_en_n;
  logic              adv_wrfull;
  logic              adv_wrreq;
  logic              adv_rdempty;
  logic              hdmi_de;
  logic              adv_rdreq;
  logic [IDX_W-1:0]  wr_sel;
  logic [IDX_W-1:0]  rd_sel;
  logic [DROP_W-1:0] drop_cnt;
  logic [2:0]        state_o;

  modport master (
    input  init_done, cam_rdempty, fb_full, fb_rd_done,
    input  fb_rd_valid, adv_wrfull, adv_rdempty, hdmi_de,
    output init_start, init_err, cam_rdreq, fb_wr_en_n,
    output fb_rd_en_n, adv_wrreq, adv_rdreq, wr_sel,
    output rd_sel, drop_cnt, state_o
  );

  modport slave (
    output init_done, cam_rdempty, fb_full, fb_rd_done,
    output fb_rd_valid, adv_wrfull, adv_rdempty, hdmi_de,
    input  init_start, init_err, cam_rdreq, fb_wr_en_n,
    input  fb_rd_en_n, adv_wrreq, adv_rdreq, wr_sel,
    input  rd_sel, drop_cnt, state_o
  );

endinterface

// File: rtl/fb_idx_pick.sv
// Lowest buffer index that is neither of two excluded indices.
// Scans downward so the lowest legal index is the last written.
module fb_idx_pick #(
  parameter int NUM_FB = 3,
  parameter int IDX_W  = 2
) (
  input  logic [IDX_W-1:0] i_ex_a,
  input  logic [IDX_W-1:0] i_ex_b,
  output logic [IDX_W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = NUM_FB - 1; i >= 0; i--) begin
      if (IDX_W'(i) != i_ex_a && IDX_W'(i) != i_ex_b)
        o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/fb_stream_seq.sv
// Frame-buffer sequencer: init handshake, prefill, streaming,
// and ping-pong / latest-frame-wins rotation over NUM_FB buffers.
module fb_stream_seq
  import fb_seq_pkg::*;
#(
  parameter int NUM_FB   = 3,
  parameter int IDX_W    = 2,
  parameter int INIT_TMO = 1000000,
  parameter int DROP_W   = 8
) (
  input logic           clk,
  input logic           reset,
  fb_stream_seq_if.master bus
);

  localparam int TMO_W = $clog2(INIT_TMO + 1);
  localparam logic [IDX_W-1:0] RD_RST = IDX_W'(NUM_FB - 1);

  state_e             r_state;
  state_e             w_nxt;
  logic [TMO_W-1:0]   r_tmo;
  logic               r_init_err;
  logic               r_rdy;
  logic [IDX_W-1:0]   r_wr_sel;
  logic [IDX_W-1:0]   r_rd_sel;
  logic [IDX_W-1:0]   r_latest;
  logic [IDX_W-1:0]   w_free;
  logic [DROP_W-1:0]  r_drop;
  logic               w_wr_act;
  logic               w_rd_act;
  logic               w_hit_full;
  logic               w_hit_done;
  logic               w_full;
  logic               w_done;
  logic               w_take;
  logic               w_cam_req;
  logic               w_valid;

  fb_idx_pick #(
    .NUM_FB (NUM_FB),
    .IDX_W  (IDX_W)
  ) u_pick (
    .i_ex_a (r_rd_sel),
    .i_ex_b (r_wr_sel),
    .o_idx  (w_free)
  );

  assign w_wr_act = (r_state == S_PREFILL) ||
                    (r_state == S_STREAM);
  assign w_rd_act = (r_state == S_STREAM);

  always_comb begin
    w_hit_full = 1'b0;
    w_hit_done = 1'b0;
    w_valid    = 1'b0;
    for (int i = 0; i < NUM_FB; i++) begin
      if (r_wr_sel == IDX_W'(i))
        w_hit_full = bus.fb_full[i];
      if (r_rd_sel == IDX_W'(i)) begin
        w_hit_done = bus.fb_rd_done[i];
        w_valid    = bus.fb_rd_valid[i];
      end
    end
  end

  assign w_full = w_wr_act & w_hit_full;
  assign w_done = w_wr_act & w_hit_done;
  // Reader may grab the frame completing this same cycle.
  assign w_take = w_done & (r_rdy | w_full);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_RESET:     w_nxt = S_INIT;
      S_INIT:      w_nxt = S_INIT_WAIT;
      S_INIT_WAIT: begin
        if (bus.init_done)
          w_nxt = S_PREFILL;
        else if (r_tmo == TMO_W'(INIT_TMO - 1))
          w_nxt = S_ERROR;
      end
      S_PREFILL: if (w_full) w_nxt = S_STREAM;
      S_STREAM:  w_nxt = S_STREAM;
      S_ERROR:   w_nxt = S_ERROR;
      default:   w_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_RESET;
      r_tmo      <= '0;
      r_init_err <= 1'b0;
      r_rdy      <= 1'b0;
      r_wr_sel   <= '0;
      r_rd_sel   <= RD_RST;
      r_latest   <= '0;
      r_drop     <= '0;
    end else begin
      r_state    <= w_nxt;
      r_tmo      <= (r_state == S_INIT_WAIT) ?
                    r_tmo + 1'b1 : '0;
      r_init_err <= r_init_err | (w_nxt == S_ERROR);
      if (NUM_FB == 2) begin
        if (w_full) begin
          r_wr_sel <= r_rd_sel;
          r_rd_sel <= r_wr_sel;
        end
      end else begin
        if (w_full) begin
          r_latest <= r_wr_sel;
          r_wr_sel <= w_free;
          if (r_rdy && !w_done && r_drop != '1)
            r_drop <= r_drop + 1'b1;
        end
        if (w_take) begin
          r_rd_sel <= w_full ? r_wr_sel : r_latest;
          r_rdy    <= 1'b0;
        end else if (w_full) begin
          r_rdy    <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.fb_wr_en_n = {NUM_FB{DEASSERT_L}};
    bus.fb_rd_en_n = {NUM_FB{DEASSERT_L}};
    w_cam_req      = w_wr_act & ~bus.cam_rdempty;
    for (int i = 0; i < NUM_FB; i++) begin
      if (w_wr_act && r_wr_sel == IDX_W'(i))
        bus.fb_wr_en_n[i] = ~w_cam_req;
      if (w_rd_act && r_rd_sel == IDX_W'(i))
        bus.fb_rd_en_n[i] = bus.adv_wrfull;
    end
  end

  assign bus.init_start = (r_state == S_INIT) ?
                          ASSERT_H : DEASSERT_H;
  assign bus.init_err   = r_init_err;
  assign bus.cam_rdreq  = w_cam_req;
  assign bus.adv_wrreq  = w_rd_act & w_valid &
                          ~bus.adv_wrfull;
  assign bus.adv_rdreq  = w_rd_act & bus.hdmi_de &
                          ~bus.adv_rdempty;
  assign bus.wr_sel     = r_wr_sel;
  assign bus.rd_sel     = r_rd_sel;
  assign bus.drop_cnt   = r_drop;
  assign bus.state_o    = r_state;

endmodule
